mem_write_checker: RTL and testbench
====================================

Name: mem_write_checker

Overview:
- Synthesizable self-checking monitor for the processor's data-memory write port.
- Compares each `memwrite` transaction (`dataadr`, `writedata`) against a programmable table of expected writes.
- Skips writes that fall in a scratch address window.
- Reports pass/fail with failure diagnostics, plus a timeout.
- Sits beside `top`; usable in simulation benches and on FPGA builds (status routed to LEDs/debug bus).

Parameters:
- ADDR_W, 32, width of `dataadr`.
- DATA_W, 32, width of `writedata`.
- NUM_EXPECT, 4, depth of the expected-write table (≥1).
- IGNORE_BASE, 80, first byte address of the scratch window.
- IGNORE_SIZE, 4, bytes in the scratch window; 0 disables the window.
- TIMEOUT_CYCLES, 1000, RUN cycles before a timeout fail; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a check run.
- cfg_we  in  1  writes one table entry.
- cfg_idx  in  IW=max(1,$clog2(NUM_EXPECT))  table entry index.
- cfg_addr  in  ADDR_W  expected address.
- cfg_data  in  DATA_W  expected data.
- cfg_num  in  IW+1  number of active entries (0..NUM_EXPECT); sampled at start.
- memwrite  in  1  write strobe from the DUT.
- dataadr  in  ADDR_W  write address.
- writedata  in  DATA_W  write data.
- busy  out  1  run in progress.
- done  out  1  run finished.
- pass  out  1  run finished with all entries matched.
- fail_code  out  2  0 none, 1 bad address, 2 bad data, 3 timeout.
- fail_addr  out  ADDR_W  address of the offending write.
- fail_data  out  DATA_W  data of the offending write.
- match_count  out  IW+1  number of entries matched so far.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; table entries 0; timeout counter 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cfg_we writes entry[cfg_idx]; indices ≥ NUM_EXPECT are ignored.
  - memwrite is ignored.
  - start → RUN. Latch cfg_num (values > NUM_EXPECT clamp to NUM_EXPECT). Clear match_count, fail_*, timeout counter.
- RUN (busy=1; cfg_we and start ignored). On each cycle with memwrite=1, in priority order:
  1. `dataadr` == entry[match_count].addr:
     - Data equal: match_count+1.
     - Data not equal: fail_code=2; latch fail_addr/fail_data; go to DONE.
  2. `dataadr` in [IGNORE_BASE, IGNORE_BASE+IGNORE_SIZE): no effect. Compute the window check at ADDR_W+1 bits so it does not wrap.
  3. Otherwise: fail_code=1; latch fail_addr/fail_data; go to DONE.
- RUN completion:
  - If match_count reaches the latched count: DONE with pass=1.
  - cfg_num=0: go to DONE with pass=1 the cycle after start.
- Timeout:
  - The counter increments every RUN cycle.
  - When it reaches TIMEOUT_CYCLES - 1 and no deciding write occurs that cycle: fail_code=3; fail_addr/fail_data=0; go to DONE.
  - If the final matching write and the timeout occur in the same cycle, the match wins (pass).
- Latency: done, pass and fail_* are registered; they are visible in the cycle after the deciding write is sampled.
- DONE:
  - done=1; all results frozen; memwrite ignored.
  - start → RUN with the same table (re-run).
  - cfg_we is allowed.
- Invariants: done and busy are never both 1; pass=1 implies fail_code=0.
- Reset asserted mid-run aborts immediately to IDLE and clears the table.

Optional Feature:
- Macro: MEM_CHK_ANY_ORDER_EN.
- Defined:
  - Entries may match in any order, using a NUM_EXPECT-bit hit vector.
  - A write matches the lowest-index unhit active entry with an equal address.
  - A write to an already-hit address with no remaining unhit duplicate is a bad-address fail (code 1).
  - Data mismatch against the selected entry is code 2.
  - pass when the hit vector covers all active entries.
- Undefined: strict in-order matching as above; no hit-vector logic.

Decomposition:
- Package mem_chk_pkg:
  - Fail-code constants FAIL_NONE/FAIL_ADDR/FAIL_DATA/FAIL_TIMEOUT.
  - FSM state enum (IDLE, RUN, DONE).
  - Table entry struct {addr, data}.
- One sub-module: mem_chk_expect_table.
  - NUM_EXPECT-entry register file; async-low-reset clear.
  - Write port; one indexed read port in in-order mode.
  - Full parallel address compare vector when MEM_CHK_ANY_ORDER_EN is defined.

Test Plan:
- Scratch then pass: entry0=(84,7), cfg_num=1, start; write (80,0x5) then (84,7) → pass=1, done=1, match_count=1, fail_code=0, one cycle after the (84,7) write.
- Bad data: entry0=(84,7); write (84,6) → done=1, pass=0, fail_code=2, fail_addr=84, fail_data=6.
- Bad address: entry0=(84,7); write (88,7) → fail_code=1, fail_addr=88; a later (84,7) write is ignored and results stay frozen.
- Timeout: TIMEOUT_CYCLES=100, no writes → fail_code=3 at exactly RUN cycle 100. Second case: final match on cycle 100 → pass.
- Sequence and re-run: entries (0,1),(4,2),(8,3), cfg_num=3; in-order writes → pass. Re-start with writes (4,2),(0,1),(8,3) → fail_code=1 without the macro; pass with MEM_CHK_ANY_ORDER_EN.
- Reset and degenerate count: assert reset mid-run → all outputs 0 immediately, state IDLE. cfg_num=0 then start → pass=1 on the next cycle.

Source files
------------

// File: rtl/mem_chk_pkg.sv
// mem_chk_pkg: shared types for the data-memory write checker.
//   FAIL_* : fail_code encodings reported by mem_write_checker
//   chk_state_e : checker FSM states
//   mem_entry_t : one expected write {addr, data} at the default bus widths
//   idx_w() : table index width, never narrower than one bit
package mem_chk_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  localparam logic [1:0] FAIL_NONE    = 2'd0;
  localparam logic [1:0] FAIL_ADDR    = 2'd1;
  localparam logic [1:0] FAIL_DATA    = 2'd2;
  localparam logic [1:0] FAIL_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} chk_state_e;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
  } mem_entry_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_chk_expect_table.sv
// mem_chk_expect_table: NUM_EXPECT-entry register file of expected writes.
//   clk, reset (async, active low: clears every entry)
//   we/widx/waddr/wdata : write port; widx >= NUM_EXPECT is dropped
//   ridx -> rdata (and raddr in in-order mode) : indexed read port
//   cmp_addr -> addr_eq : per-entry address compare (MEM_CHK_ANY_ORDER_EN only)
module mem_chk_expect_table
  import mem_chk_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int NUM_EXPECT = 4,
  parameter int IW         = idx_w(NUM_EXPECT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [IW-1:0]         widx,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [IW-1:0]         ridx,
`ifdef MEM_CHK_ANY_ORDER_EN
  input  logic [ADDR_W-1:0]     cmp_addr,
  output logic [NUM_EXPECT-1:0] addr_eq,
`else
  output logic [ADDR_W-1:0]     raddr,
`endif
  output logic [DATA_W-1:0]     rdata
);

  logic [NUM_EXPECT-1:0][ADDR_W-1:0] ent_addr;
  logic [NUM_EXPECT-1:0][DATA_W-1:0] ent_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_addr <= '0;
      ent_data <= '0;
    end else if (we) begin
      // Out-of-range indices match no entry and are dropped.
      for (int i = 0; i < NUM_EXPECT; i++)
        if (widx == IW'(i)) begin
          ent_addr[i] <= waddr;
          ent_data[i] <= wdata;
        end
    end
  end

  // Guard only matters when NUM_EXPECT is not a power of two.
  assign rdata = (32'(ridx) < NUM_EXPECT) ? ent_data[ridx] : '0;

`ifdef MEM_CHK_ANY_ORDER_EN
  for (genvar i = 0; i < NUM_EXPECT; i++) begin : g_cmp
    assign addr_eq[i] = (ent_addr[i] == cmp_addr);
  end
`else
  assign raddr = (32'(ridx) < NUM_EXPECT) ? ent_addr[ridx] : '0;
`endif

endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker: monitors the data-memory write port against a table
// of expected writes; writes inside the scratch window are skipped.
//   clk, reset (async, active low)
//   start : pulse, begins a run (from IDLE or DONE); cfg_num sampled here
//   cfg_we/cfg_idx/cfg_addr/cfg_data : table load, ignored while busy
//   memwrite/dataadr/writedata : observed write port
//   busy, done, pass, fail_code, fail_addr, fail_data, match_count : status
// Build option MEM_CHK_ANY_ORDER_EN: entries may match in any order
// (hit vector); otherwise entries must match strictly in table order.
module mem_write_checker
  import mem_chk_pkg::*;
#(
  parameter int ADDR_W         = MEM_ADDR_W,
  parameter int DATA_W         = MEM_DATA_W,
  parameter int NUM_EXPECT     = 4,
  parameter int IGNORE_BASE    = 80,
  parameter int IGNORE_SIZE    = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int IW            = idx_w(NUM_EXPECT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cfg_we,
  input  logic [IW-1:0]     cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [IW:0]       cfg_num,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [IW:0]       match_count
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW:0]   NUM_MAX  = (IW+1)'(NUM_EXPECT);
  // One extra bit so BASE+SIZE at the top of the address space cannot wrap.
  localparam logic [ADDR_W:0] WIN_LO = (ADDR_W+1)'(IGNORE_BASE);
  localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ADDR_W+1)'(IGNORE_SIZE);

  chk_state_e        state_q, state_d;
  logic [IW:0]       num_q, num_d, cnt_q, cnt_d, cnt_inc, num_clamp;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              pass_q, pass_d, decide, in_win, addr_hit;
  logic [1:0]        code_q, code_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic [DATA_W-1:0] fdata_q, fdata_d, rdata;
  logic [IW-1:0]     ridx;

  assign in_win    = ({1'b0, dataadr} >= WIN_LO) && ({1'b0, dataadr} < WIN_HI);
  assign cnt_inc   = cnt_q + 1'b1;
  assign num_clamp = (cfg_num > NUM_MAX) ? NUM_MAX : cfg_num;

`ifdef MEM_CHK_ANY_ORDER_EN
  logic [NUM_EXPECT-1:0] hit_q, hit_d, addr_eq, active, cand;
  logic [IW-1:0]         sel_idx;

  // Candidate = active, not yet hit, same address; lowest index wins.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_EXPECT; i++) active[i] = ((IW+1)'(i) < num_q);
    cand = addr_eq & ~hit_q & active;
    for (int i = NUM_EXPECT - 1; i >= 0; i--)
      if (cand[i]) sel_idx = IW'(i);
  end
  assign addr_hit = |cand;
  assign ridx     = sel_idx;

  mem_chk_expect_table #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_EXPECT(NUM_EXPECT), .IW(IW)
  ) u_tab (
    .clk(clk), .reset(reset), .we(cfg_we && state_q != RUN),
    .widx(cfg_idx), .waddr(cfg_addr), .wdata(cfg_data),
    .ridx(ridx), .cmp_addr(dataadr), .addr_eq(addr_eq), .rdata(rdata)
  );
`else
  logic [ADDR_W-1:0] raddr;

  // cnt_q < num_q <= NUM_EXPECT while running, so the index is in range.
  assign ridx     = cnt_q[IW-1:0];
  assign addr_hit = (dataadr == raddr);

  mem_chk_expect_table #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_EXPECT(NUM_EXPECT), .IW(IW)
  ) u_tab (
    .clk(clk), .reset(reset), .we(cfg_we && state_q != RUN),
    .widx(cfg_idx), .waddr(cfg_addr), .wdata(cfg_data),
    .ridx(ridx), .raddr(raddr), .rdata(rdata)
  );
`endif

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    pass_d  = pass_q;
    code_d  = code_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    decide  = 1'b0;
`ifdef MEM_CHK_ANY_ORDER_EN
    hit_d   = hit_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          num_d   = num_clamp;
          cnt_d   = '0;
          tmo_d   = '0;
          pass_d  = 1'b0;
          code_d  = FAIL_NONE;
          faddr_d = '0;
          fdata_d = '0;
`ifdef MEM_CHK_ANY_ORDER_EN
          hit_d   = '0;
`endif
          // Empty table: nothing to wait for, report pass straight away.
          if (num_clamp == '0) begin
            state_d = DONE;
            pass_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        tmo_d = tmo_q + 1'b1;
        if (memwrite) begin
          if (addr_hit) begin
            if (writedata == rdata) begin
              cnt_d = cnt_inc;
`ifdef MEM_CHK_ANY_ORDER_EN
              hit_d[sel_idx] = 1'b1;
`endif
              if (cnt_inc == num_q) begin
                state_d = DONE;
                pass_d  = 1'b1;
                decide  = 1'b1;
              end
            end else begin
              state_d = DONE;
              code_d  = FAIL_DATA;
              faddr_d = dataadr;
              fdata_d = writedata;
              decide  = 1'b1;
            end
          end else if (!in_win) begin
            state_d = DONE;
            code_d  = FAIL_ADDR;
            faddr_d = dataadr;
            fdata_d = writedata;
            decide  = 1'b1;
          end
        end
        // A deciding write in the last cycle takes precedence over timeout.
        if (TIMEOUT_CYCLES != 0 && !decide && tmo_q == TMO_LAST) begin
          state_d = DONE;
          code_d  = FAIL_TIMEOUT;
          faddr_d = '0;
          fdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      num_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      pass_q  <= 1'b0;
      code_q  <= FAIL_NONE;
      faddr_q <= '0;
      fdata_q <= '0;
`ifdef MEM_CHK_ANY_ORDER_EN
      hit_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      pass_q  <= pass_d;
      code_q  <= code_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
`ifdef MEM_CHK_ANY_ORDER_EN
      hit_q   <= hit_d;
`endif
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign pass        = pass_q;
  assign fail_code   = code_q;
  assign fail_addr   = faddr_q;
  assign fail_data   = fdata_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: table-driven single-write vectors plus hand-written
// multi-cycle sequences; expected status records go through a queue.
module tb_mem_write_checker;
  import mem_chk_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, cfg_we, memwrite;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_addr, cfg_data, dataadr, writedata;
  logic [2:0]  cfg_num;
  logic        busy, done, pass;
  logic [1:0]  fail_code;
  logic [31:0] fail_addr, fail_data;
  logic [2:0]  match_count;

  int n_chk = 0;
  int n_fail = 0;

  mem_write_checker #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_num(cfg_num), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .busy(busy), .done(done), .pass(pass),
    .fail_code(fail_code), .fail_addr(fail_addr), .fail_data(fail_data),
    .match_count(match_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        busy, done, pass;
    logic [1:0]  code;
    logic [31:0] faddr, fdata;
    logic [2:0]  cnt;
  } res_t;

  typedef struct {
    mem_entry_t ent;
    mem_entry_t wr;
    res_t       r;
  } vec_t;

  res_t exp_q[$];
  vec_t vt[9];

  function automatic res_t mk(input logic b, input logic d, input logic p,
                              input logic [1:0] c, input logic [31:0] fa,
                              input logic [31:0] fd, input logic [2:0] n);
    res_t r;
    r.busy = b; r.done = d; r.pass = p; r.code = c;
    r.faddr = fa; r.fdata = fd; r.cnt = n;
    return r;
  endfunction

  function automatic mem_entry_t me(input logic [31:0] a, input logic [31:0] d);
    mem_entry_t e;
    e.addr = a; e.data = d;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string nm);
    res_t e;
    if (exp_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: scoreboard empty, got done=%0b expected an entry", nm, done);
      return;
    end
    e = exp_q.pop_front();
    chk({nm, ".busy"},  32'(busy),        32'(e.busy));
    chk({nm, ".done"},  32'(done),        32'(e.done));
    chk({nm, ".pass"},  32'(pass),        32'(e.pass));
    chk({nm, ".code"},  32'(fail_code),   32'(e.code));
    chk({nm, ".faddr"}, fail_addr,        e.faddr);
    chk({nm, ".fdata"}, fail_data,        e.fdata);
    chk({nm, ".cnt"},   32'(match_count), 32'(e.cnt));
    chk({nm, ".busy_and_done"}, 32'(busy & done), 32'd0);
    chk({nm, ".pass_code"}, 32'(pass && fail_code != 2'd0), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string nm, input res_t e);
    exp_q.push_back(e);
    check_out(nm);
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; cfg_we = 1'b0; memwrite = 1'b0;
    cfg_idx = '0; cfg_addr = '0; cfg_data = '0; cfg_num = '0;
    dataadr = '0; writedata = '0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic cfg(input int idx, input logic [31:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic run(input int num);
    cfg_num = 3'(num); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wr(input string nm, input logic [31:0] a, input logic [31:0] d, input res_t e);
    memwrite = 1'b1; dataadr = a; writedata = d;
    exp_q.push_back(e);
    tick();
    memwrite = 1'b0;
    check_out(nm);
  endtask

  res_t r_busy0, r_zero;

  initial begin
    r_zero  = mk(0, 0, 0, 2'd0, 0, 0, 0);
    r_busy0 = mk(1, 0, 0, 2'd0, 0, 0, 0);
    vt[0] = '{me(84, 7),  me(84, 7),  mk(0, 1, 1, 2'd0, 0, 0, 1)};
    vt[1] = '{me(84, 7),  me(84, 6),  mk(0, 1, 0, 2'd2, 84, 6, 0)};
    vt[2] = '{me(84, 7),  me(88, 7),  mk(0, 1, 0, 2'd1, 88, 7, 0)};
    vt[3] = '{me(84, 7),  me(80, 5),  r_busy0};
    vt[4] = '{me(100, 1), me(84, 2),  mk(0, 1, 0, 2'd1, 84, 2, 0)};
    vt[5] = '{me(84, 7),  me(79, 5),  mk(0, 1, 0, 2'd1, 79, 5, 0)};
    vt[6] = '{me(80, 9),  me(80, 9),  mk(0, 1, 1, 2'd0, 0, 0, 1)};
    vt[7] = '{me(80, 9),  me(80, 8),  mk(0, 1, 0, 2'd2, 80, 8, 0)};
    vt[8] = '{me(100, 1), me(83, 2),  r_busy0};

    for (int i = 0; i < 9; i++) begin
      do_reset();
      expect_now($sformatf("vec%0d.reset", i), r_zero);
      cfg(0, vt[i].ent.addr, vt[i].ent.data);
      run(1);
      expect_now($sformatf("vec%0d.start", i), r_busy0);
      wr($sformatf("vec%0d.write", i), vt[i].wr.addr, vt[i].wr.data, vt[i].r);
    end

    // Scratch write, then the expected write.
    do_reset();
    cfg(0, 84, 7); run(1);
    wr("scratch.skip", 80, 5, r_busy0);
    wr("scratch.pass", 84, 7, mk(0, 1, 1, 2'd0, 0, 0, 1));

    // Bad address, then results stay frozen.
    do_reset();
    cfg(0, 84, 7); run(1);
    wr("badaddr.fail",   88, 7, mk(0, 1, 0, 2'd1, 88, 7, 0));
    wr("badaddr.frozen", 84, 7, mk(0, 1, 0, 2'd1, 88, 7, 0));

    // Timeout fires at the end of RUN cycle 100.
    do_reset();
    cfg(0, 84, 7); run(1);
    repeat (99) tick();
    expect_now("timeout.cycle99", r_busy0);
    tick();
    expect_now("timeout.cycle100", mk(0, 1, 0, 2'd3, 0, 0, 0));

    // Final match in cycle 100 wins over the timeout.
    do_reset();
    cfg(0, 84, 7); run(1);
    repeat (99) tick();
    wr("timeout.match_wins", 84, 7, mk(0, 1, 1, 2'd0, 0, 0, 1));

    // Three-entry sequence, then re-run out of order.
    do_reset();
    cfg(0, 0, 1); cfg(1, 4, 2); cfg(2, 8, 3);
    run(3);
    wr("seq.w0", 0, 1, mk(1, 0, 0, 2'd0, 0, 0, 1));
    wr("seq.w1", 4, 2, mk(1, 0, 0, 2'd0, 0, 0, 2));
    wr("seq.w2", 8, 3, mk(0, 1, 1, 2'd0, 0, 0, 3));
    run(3);
    expect_now("rerun.start", r_busy0);
`ifdef MEM_CHK_ANY_ORDER_EN
    wr("rerun.w4", 4, 2, mk(1, 0, 0, 2'd0, 0, 0, 1));
    wr("rerun.w0", 0, 1, mk(1, 0, 0, 2'd0, 0, 0, 2));
    wr("rerun.w8", 8, 3, mk(0, 1, 1, 2'd0, 0, 0, 3));
`else
    wr("rerun.w4", 4, 2, mk(0, 1, 0, 2'd1, 4, 2, 0));
`endif

    // cfg_num above NUM_EXPECT clamps to 4.
    do_reset();
    for (int i = 0; i < 4; i++) cfg(i, 32'(16 + 4 * i), 32'(i + 1));
    run(7);
    for (int i = 0; i < 3; i++)
      wr($sformatf("clamp.w%0d", i), 32'(16 + 4 * i), 32'(i + 1), mk(1, 0, 0, 2'd0, 0, 0, 3'(i + 1)));
    wr("clamp.w3", 28, 4, mk(0, 1, 1, 2'd0, 0, 0, 4));

    // Empty table passes right after start (re-run from DONE).
    run(0);
    expect_now("num0.pass", mk(0, 1, 1, 2'd0, 0, 0, 0));

    // Reset mid-run clears outputs at once and clears the table.
    do_reset();
    cfg(0, 84, 7); run(1);
    wr("midreset.skip", 80, 5, r_busy0);
    #2 reset = 1'b0;
    #1 expect_now("midreset.async", r_zero);
    tick();
    reset = 1'b1;
    run(1);
    wr("midreset.table_cleared", 84, 7, mk(0, 1, 0, 2'd1, 84, 7, 0));
    do_reset();
    run(1);
    wr("midreset.entry0_zero", 0, 0, mk(0, 1, 1, 2'd0, 0, 0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
